// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, WIDTH cycles per add, LSB first.
// Optional subtract mode enabled by defining SERIAL_ADDER_SUB_EN (adds input port sub).
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef logic [CntW-1:0] cnt_t;
  localparam cnt_t LastCnt = cnt_t'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  cnt_t             count_q, count_d;

  logic [WIDTH-1:0] b_load;
  logic             carry_load;
  logic             bit_s, bit_c;
  logic [WIDTH-1:0] sum_shift;

  // Subtraction is A + ~B + 1: invert B and force the carry-in on capture.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load     = sub ? ~B : B;
  assign carry_load = sub ? 1'b1 : Cin;
`else
  assign b_load     = B;
  assign carry_load = Cin;
`endif

  assign bit_s     = a_q[0] ^ b_q[0] ^ carry_q;
  assign bit_c     = (a_q[0] & b_q[0]) | (b_q[0] & carry_q) | (a_q[0] & carry_q);
  assign sum_shift = {bit_s, sum_sr_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_sr_d = sum_sr_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    count_d  = count_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StAdd;
          a_d     = A;
          b_d     = b_load;
          carry_d = carry_load;
          count_d = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StAdd: begin
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        sum_sr_d = sum_shift;
        carry_d  = bit_c;
        count_d  = count_q + cnt_t'(1);
        if (count_q == LastCnt) begin
          state_d = StDone;
          sum_d   = sum_shift;
          cout_d  = bit_c;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      sum_sr_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_sr_q <= sum_sr_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      count_q  <= count_d;
    end
  end

  assign busy = (state_q == StAdd);
  assign done = (state_q == StDone);
  assign Sum  = sum_q;
  assign Cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: vector table, hand-written corner sequences and a random run
// against an arithmetic reference model.
module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A, B;
  logic         Cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
`endif
  logic         busy, done;
  logic [W-1:0] Sum;
  logic         Cout;

  int tests = 0;
  int fails = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub  (sub),
`endif
    .busy (busy),
    .done (done),
    .Sum  (Sum),
    .Cout (Cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive a start for one cycle, then scramble operands to prove they were captured.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    @(posedge clk);
    #1;
    A = a; B = b; Cin = ci; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
  endtask

  // Counts negedges after the accepting edge until done; lat=0 if it never comes.
  task automatic wait_done(output int lat, output int nbusy);
    lat = 0;
    nbusy = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic expect_result(input string name, input logic [W-1:0] es, input logic ec);
    int lat, nb;
    wait_done(lat, nb);
    check({name, " latency"}, lat, W + 1);
    check({name, " busy cycles"}, nb, W);
    check({name, " Sum"}, Sum, es);
    check({name, " Cout"}, Cout, ec);
  endtask

  initial begin
    int nd, first, t;
    logic [W-1:0] ra, rb, es;
    logic rc, rs, ec;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[6] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};

    rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle busy", busy, 0);
    check("idle done", done, 0);
    check("idle Sum", Sum, 0);
    check("idle Cout", Cout, 0);

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].cin);
      expect_result($sformatf("vec%0d", i), vecs[i].s, vecs[i].co);
    end

    // Result held and done is a single pulse
    @(negedge clk);
    check("hold done low", done, 0);
    check("hold Sum", Sum, 8'h00);
    check("hold Cout", Cout, 1);

    // Back-to-back: second start issued during the done cycle
    launch(8'hFF, 8'h01, 1'b0);
    expect_result("b2b first", 8'h00, 1'b1);
    A = 8'hFF; B = 8'hFF; Cin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = W'($urandom); B = W'($urandom);
    check("b2b busy after accept", busy, 1);
    check("b2b Sum held", Sum, 8'h00);
    expect_result("b2b second", 8'hFF, 1'b1);

    // start during ADD is ignored
    launch(8'h12, 8'h34, 1'b0);
    nd = 0;
    first = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 3) begin
        start = 1'b1;
        A = 8'hAA;
      end else if (n == 4) begin
        start = 1'b0;
      end
      if (done) begin
        nd++;
        if (first == 0) first = n;
      end
    end
    check("midadd done count", nd, 1);
    check("midadd latency", first, W + 1);
    check("midadd Sum", Sum, 8'h46);
    check("midadd Cout", Cout, 0);

    // Reset mid-ADD aborts with no done
    launch(8'h80, 8'h80, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort Sum", Sum, 0);
    check("abort Cout", Cout, 0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    check("abort no activity", nd, 0);

    // Release reset with start already high
    rst = 1'b1;
    A = 8'h80; B = 8'h80; Cin = 1'b0; start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = W'($urandom); B = W'($urandom);
    expect_result("post-reset", 8'h00, 1'b1);

`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b1;
    launch(8'h05, 8'h07, 1'b0);
    expect_result("sub 5-7", 8'hFE, 1'b0);
    launch(8'h07, 8'h05, 1'b0);
    expect_result("sub 7-5", 8'h02, 1'b1);
    sub = 1'b0;
`endif

    // Random operations against an arithmetic model
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      rs = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom);
      sub = rs;
`endif
      if (rs) begin
        t  = int'(ra) - int'(rb);
        es = W'(t);
        ec = (ra >= rb);
      end else begin
        t  = int'(ra) + int'(rb) + int'(rc);
        es = W'(t);
        ec = ((t >> W) & 1) != 0;
      end
      launch(ra, rb, rc);
      expect_result($sformatf("rand%0d a=%0h b=%0h c=%0b s=%0b", i, ra, rb, rc, rs), es, ec);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
